// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Streams words from a valid/ready source into consecutive memory
//            addresses, wrapping modulo DEPTH. It then reads the region back
//            through a combinational read port and checks an additive
//            checksum against the sum of the words written.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wbdata,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int                 c_CNT_W     = ADDR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FLUSH  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_CNT_W-1:0]  r_idx;
  logic [c_CNT_W-1:0]  r_vidx;
  logic [DATA_W-1:0]   r_wsum;
  logic [DATA_W-1:0]   r_rsum;
  logic [DATA_W-1:0]   r_wbdata;
  logic [DATA_W-1:0]   r_checksum;
  logic [ADDR_W-1:0]   r_waddr;
  logic                r_we;
  logic                r_err;
  logic                w_xfer;
  logic                w_bad_count;
  logic [DATA_W-1:0]   w_rsum_next;

  // A job with a zero or oversized count skips straight to DONE.
  assign w_bad_count = (count > c_DEPTH_CNT);
  assign w_rsum_next = r_rsum + rd_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    w_xfer   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (count == '0 || w_bad_count) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        w_xfer   = in_valid;
        if (in_valid && r_idx == r_count - c_ONE) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy   = 1'b1;
        w_next = S_VERIFY;
      end
      S_VERIFY: begin
        busy = 1'b1;
        if (r_vidx == r_count - c_ONE) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job datapath: write port, running sums, indices and latched result.
  // Result registers load on the VERIFY->DONE edge so they are valid with done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base     <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_vidx     <= '0;
      r_wsum     <= '0;
      r_rsum     <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wbdata   <= '0;
      r_err      <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_waddr  <= r_base + r_idx[ADDR_W-1:0];
        r_wbdata <= in_data;
        r_wsum   <= r_wsum + in_data;
        r_idx    <= r_idx + c_ONE;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_count    <= count;
            r_idx      <= '0;
            r_vidx     <= '0;
            r_wsum     <= '0;
            r_rsum     <= '0;
            r_err      <= w_bad_count;
            r_checksum <= '0;
          end
        end
        S_FLUSH: begin
          r_vidx <= '0;
        end
        S_VERIFY: begin
          r_rsum <= w_rsum_next;
          r_vidx <= r_vidx + c_ONE;
          if (w_next == S_DONE) begin
            r_checksum <= r_wsum;
            r_err      <= (w_rsum_next != r_wsum);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr  = (r_state == S_VERIFY) ? (r_base + r_vidx[ADDR_W-1:0]) : '0;
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wbdata   = r_wbdata;
  assign err      = r_err;
  assign checksum = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Self-checking bench for mem_loader. Jobs are modelled as lists of
//            (address, word) writes plus a final (checksum, err) result; a
//            negedge monitor pops and compares whenever the DUT writes or
//            pulses done. A memory model serves the read port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wbdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] checksum;

  mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wbdata(wbdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit corrupt = 1'b0;

  typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct packed { logic [DATA_W-1:0] sum; logic er; } dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];

  // Memory model: single write port, combinational read, optional corruption.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (we) mem[waddr] <= wbdata;
  always @* rd_data = mem[rd_addr] + ((corrupt && rd_addr == 5'd2) ? 32'd1 : 32'd0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every DUT write and every done pulse consumes one expectation.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", waddr, wbdata);
      end else begin
        w = exp_wr.pop_front();
        chk("waddr", 64'(waddr), 64'(w.a));
        chk("wbdata", 64'(wbdata), 64'(w.d));
      end
    end
    if (done === 1'b1) begin
      if (exp_dn.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=done required=no done");
      end else begin
        d = exp_dn.pop_front();
        chk("checksum", 64'(checksum), 64'(d.sum));
        chk("err", 64'(err), 64'(d.er));
      end
    end
  end

  // Runs one job. Called #1 after a posedge with the DUT idle.
  // dmode: 0 random, 1 words 1..n, 2 all ones. vmode: 0 always, 1 toggle, 2 random.
  task automatic run_job(input int b, input int n, input int dmode, input int vmode, input bit poke);
    logic [DATA_W-1:0] words[$];
    logic [DATA_W-1:0] sum;
    bit hit;
    bit ok;
    int sent;
    int last;
    int done_k;
    wr_t t;
    dn_t dd;
    sum = '0; hit = 1'b0; sent = 0; last = 0; done_k = -1;
    ok = (n >= 1 && n <= DEPTH);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        logic [DATA_W-1:0] wv;
        wv = (dmode == 1) ? 32'(i + 1) : (dmode == 2) ? 32'hFFFF_FFFF : $urandom;
        words.push_back(wv);
        sum += wv;
        t.a = 5'(b + i);
        t.d = wv;
        exp_wr.push_back(t);
        if (corrupt && t.a == 5'd2) hit = 1'b1;
      end
    end
    dd.sum = sum;
    dd.er  = (n > DEPTH) ? 1'b1 : hit;
    exp_dn.push_back(dd);

    start = 1'b1; base_addr = 5'(b); count = 6'(n); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 5'($urandom); count = 6'($urandom);
    for (int k = 1; k < 400; k++) begin
      start = (poke && k == 2);
      in_valid = ok && sent < n &&
                 (vmode == 0 || (vmode == 1 && k % 2 == 1) ||
                  (vmode == 2 && $urandom_range(0, 1) == 1));
      in_data = in_valid ? words[sent] : $urandom;
      @(negedge clk);
      if (ok && sent < n) begin
        chk("in_ready_load", 64'(in_ready), 64'd1);
        chk("busy_load", 64'(busy), 64'd1);
      end
      if (in_valid && in_ready) begin
        sent++;
        last = k;
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("done_cycle", 64'(done_k), ok ? 64'(last + n + 2) : 64'd1);
    if (done_k >= 0) chk("busy_at_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("queues_empty", 64'(exp_wr.size() + exp_dn.size()), 64'd0);
    exp_wr.delete();
    exp_dn.delete();
    @(posedge clk); #1;
  endtask

  // Reset mid-LOAD after two accepted words of a five-word job.
  task automatic abort_job(input int b);
    wr_t t;
    start = 1'b1; base_addr = 5'(b); count = 6'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      t.a = 5'(b + i);
      t.d = in_data;
      exp_wr.push_back(t);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_we", 64'(we), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    chk("abort_queue", 64'(exp_wr.size() + exp_dn.size()), 64'd0);
    exp_wr.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wbdata", 64'(wbdata), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_job(0, 4, 1, 0, 1'b0);
    run_job(30, 4, 2, 0, 1'b0);
    run_job(7, 3, 0, 1, 1'b0);
    corrupt = 1'b1;
    run_job(0, 4, 0, 0, 1'b0);
    corrupt = 1'b0;
    run_job(12, 0, 0, 0, 1'b0);
    run_job(12, 33, 0, 0, 1'b0);
    run_job(20, 6, 0, 0, 1'b1);
    run_job(3, 32, 0, 2, 1'b0);
    abort_job(9);
    run_job(9, 5, 0, 0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      corrupt = ($urandom_range(0, 3) == 0);
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(1, 32)), 0, 2,
              bit'($urandom_range(0, 1)));
    end
    corrupt = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
